// File: rtl/imem_pkg.sv
// Shared constants, types and address decode for the instruction-memory responder.
package imem_pkg;

  localparam logic        IMEM_ERR_NONE  = 1'b0;
  localparam logic        IMEM_ERR_FAULT = 1'b1;
  localparam logic [31:0] NOP_ON_FAULT   = 32'h0000_0000;

  // Wide enough for any supported request address width.
  localparam int unsigned WIDE_W = 64;

  typedef struct packed {
    logic              oob;
    logic              misaligned;
    logic [WIDE_W-1:0] index;
  } word_idx_t;

  // The byte offset wraps at addr_w bits before the range check, so addresses
  // below the base land far out of range instead of aliasing into the array.
  function automatic word_idx_t word_index(input logic [WIDE_W-1:0] addr,
                                           input logic [WIDE_W-1:0] base,
                                           input int unsigned       addr_w,
                                           input int unsigned       depth);
    word_idx_t         res;
    logic [WIDE_W-1:0] mask;
    logic [WIDE_W-1:0] off;
    mask           = (addr_w >= WIDE_W) ? '1 : ((WIDE_W'(1) << addr_w) - WIDE_W'(1));
    off            = (addr - base) & mask;
    res.misaligned = (addr[1:0] != 2'b00);
    res.index      = off >> 2;
    res.oob        = (res.index >= WIDE_W'(depth));
    return res;
  endfunction

endpackage

// File: rtl/imem_fetch_resp_if.sv
// Fetch request / instruction response bus between the PC side and the memory.
interface imem_fetch_resp_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_inst;
  logic              resp_err;

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_inst,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_inst,
    output resp_err
  );

endinterface

// File: rtl/imem_resp_fifo.sv
// Two-entry in-order response buffer of {err, inst}; entry 0 is the head.
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_inst,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic              o_valid,
  output logic              o_head_err,
  output logic [DATA_W-1:0] o_head_inst
);

  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic              r_err0;
  logic              r_err1;
  logic              w_err0_nxt;
  logic              w_err1_nxt;
  logic [DATA_W-1:0] r_inst0;
  logic [DATA_W-1:0] r_inst1;
  logic [DATA_W-1:0] w_inst0_nxt;
  logic [DATA_W-1:0] w_inst1_nxt;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // Entries only shift down when a second entry exists, so an emptied buffer
  // keeps presenting the last delivered response.
  always_comb begin
    w_count_nxt = r_count;
    w_err0_nxt  = r_err0;
    w_err1_nxt  = r_err1;
    w_inst0_nxt = r_inst0;
    w_inst1_nxt = r_inst1;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) begin
          w_err0_nxt  = i_err;
          w_inst0_nxt = i_inst;
        end else begin
          w_err1_nxt  = i_err;
          w_inst1_nxt = i_inst;
        end
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        if (r_count == 2'd2) begin
          w_err0_nxt  = r_err1;
          w_inst0_nxt = r_inst1;
        end
        w_count_nxt = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          w_err0_nxt  = i_err;
          w_inst0_nxt = i_inst;
        end else begin
          w_err0_nxt  = r_err1;
          w_inst0_nxt = r_inst1;
          w_err1_nxt  = i_err;
          w_inst1_nxt = i_inst;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 2'd0;
      r_err0  <= IMEM_ERR_NONE;
      r_err1  <= IMEM_ERR_NONE;
      r_inst0 <= '0;
      r_inst1 <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_err0  <= w_err0_nxt;
      r_err1  <= w_err1_nxt;
      r_inst0 <= w_inst0_nxt;
      r_inst1 <= w_inst1_nxt;
    end
  end

  assign o_count     = r_count;
  assign o_valid     = (r_count != 2'd0);
  assign o_head_err  = r_err0;
  assign o_head_inst = r_inst0;

endmodule

// File: rtl/imem_fetch_resp.sv
// Instruction memory responder: word array, registered read stage and a
// two-entry response buffer behind a valid/ready fetch interface.
module imem_fetch_resp
  import imem_pkg::*;
#(
  parameter int unsigned       DEPTH_WORDS = 64,
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  localparam int unsigned      IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_resp_if.slave  bus,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic              r_s1_valid;
  logic              r_s1_err;
  logic [DATA_W-1:0] r_s1_inst;

  word_idx_t         w_wi;
  logic              w_fault;
  logic [IDX_W-1:0]  w_rd_idx;
  logic              w_unused_idx;
  logic              w_accept;
  logic              w_pop;
  logic              w_s1_move;
  logic [1:0]        w_count;
  logic              w_resp_valid;
  logic              w_head_err;
  logic [DATA_W-1:0] w_head_inst;

  assign w_wi         = word_index(WIDE_W'(bus.req_addr), WIDE_W'(BASE_ADDR), ADDR_W,
                                   DEPTH_WORDS);
  assign w_fault      = w_wi.oob || w_wi.misaligned;
  assign w_rd_idx     = w_fault ? '0 : w_wi.index[IDX_W-1:0];
  assign w_unused_idx = ^w_wi.index[WIDE_W-1:IDX_W];

  // Ready depends only on registered occupancy, never on resp_ready.
  assign bus.req_ready = (({1'b0, r_s1_valid} + w_count) < 2'd3);

  assign w_accept  = bus.req_valid && bus.req_ready;
  assign w_pop     = w_resp_valid && bus.resp_ready;
  assign w_s1_move = r_s1_valid && ((w_count < 2'd2) || w_pop);

  // No reset: contents survive rst, and loads are accepted while it is held.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= IMEM_ERR_NONE;
      r_s1_inst  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_err   <= w_fault ? IMEM_ERR_FAULT : IMEM_ERR_NONE;
      r_s1_inst  <= w_fault ? DATA_W'(NOP_ON_FAULT) : r_mem[w_rd_idx];
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  imem_resp_fifo #(
    .DATA_W (DATA_W)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_s1_move),
    .i_err       (r_s1_err),
    .i_inst      (r_s1_inst),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_valid     (w_resp_valid),
    .o_head_err  (w_head_err),
    .o_head_inst (w_head_inst)
  );

  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_err   = w_head_err;
  assign bus.resp_inst  = w_head_inst;

  // s1 only enters a full buffer on a cycle that also drains it.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (w_s1_move && (w_count == 2'd2)) |-> w_pop);

  a_no_accept_while_full: assert property (@(posedge clk) disable iff (rst)
    (r_s1_valid && (w_count == 2'd2)) |-> !w_accept);

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Randomised bench for imem_fetch_resp against an address-rule reference model.
module tb_imem_fetch_resp;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;

  imem_fetch_resp_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_fetch_resp #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .DATA_W      (32),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_q [$];

  logic        acc;
  logic        popd;
  logic        p_err;
  logic [31:0] p_inst;

  // Expected {err, inst} for one fetch, from the address rules alone.
  function automatic logic [32:0] ref_fetch(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr[1:0] != 2'b00) return {1'b1, 32'h0};
    if ((off >> 2) >= DEPTH) return {1'b1, 32'h0};
    return {1'b0, ref_mem[int'(off >> 2)]};
  endfunction

  function automatic logic [31:0] rand_addr();
    return BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
  endfunction

  // One clock: drive at the negedge, sample just after, model the coming edge.
  task automatic step(input logic v, input logic [31:0] a, input logic rr,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd);
    bus.req_valid  = v;
    bus.req_addr   = a;
    bus.resp_ready = rr;
    wr_en          = we;
    wr_addr        = wa;
    wr_data        = wd;
    #1;
    acc    = v && bus.req_ready && !rst;
    popd   = bus.resp_valid && rr && !rst;
    p_inst = bus.resp_inst;
    p_err  = bus.resp_err;
    if (acc) exp_q.push_back(ref_fetch(a));
    if (we) ref_mem[wa] = wd;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] w;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      w = (i < 4) ? 32'(32'h11 * (i + 1)) : $urandom;
      step(1'b0, 32'h0, 1'b0, 1'b1, 6'(i), w);
    end
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid: got %b, required 0", bus.resp_valid);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b, required 1", bus.req_ready);
    end
    n_checks++;
    if (bus.resp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_err: got %b, required 0", bus.resp_err);
    end
    n_checks++;
    if (bus.resp_inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp_inst: got %h, required 0", bus.resp_inst);
    end
  endtask

  task automatic test_stream();
    int          pop_cyc[$];
    logic [32:0] e;
    for (int c = 0; c < 10; c++) begin
      step(c < 4, 32'(c * 4), 1'b1, 1'b0, 6'd0, 32'h0);
      if (c < 4) begin
        n_checks++;
        if (acc !== 1'b1) begin
          n_fail++; $display("FAIL stream_accept[%0d]: got %b, required 1", c, acc);
        end
      end
      if (popd) begin
        pop_cyc.push_back(c);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra_resp: got %h, required none", p_inst);
        end else begin
          e = exp_q.pop_front();
          if ({p_err, p_inst} !== e) begin
            n_fail++; $display("FAIL stream_data: got %h, required %h", {p_err, p_inst}, e);
          end
        end
        n_checks++;
        if (p_inst !== 32'(32'h11 * pop_cyc.size())) begin
          n_fail++; $display("FAIL stream_word: got %h, required %h", p_inst,
                             32'(32'h11 * pop_cyc.size()));
        end
      end
    end
    n_checks++;
    if (pop_cyc.size() != 4) begin
      n_fail++; $display("FAIL stream_count: got %0d, required 4", pop_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (pop_cyc[i] != i + 2) begin
          n_fail++; $display("FAIL stream_latency[%0d]: got cycle %0d, required %0d",
                             i, pop_cyc[i], i + 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int          n_acc = 0;
    int          n_pop = 0;
    logic [32:0] e;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, rand_addr(), 1'b0, 1'b0, 6'd0, 32'h0);
      if (acc) n_acc++;
    end
    n_checks++;
    if (n_acc != 3) begin
      n_fail++; $display("FAIL bp_accepts: got %0d, required 3", n_acc);
    end
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: got %b, required 0", bus.req_ready);
    end
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
      if (popd) begin
        n_pop++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_resp: got %h, required none", p_inst);
        end else begin
          e = exp_q.pop_front();
          if ({p_err, p_inst} !== e) begin
            n_fail++; $display("FAIL bp_data: got %h, required %h", {p_err, p_inst}, e);
          end
        end
      end
    end
    n_checks++;
    if (n_pop != 3) begin
      n_fail++; $display("FAIL bp_drain_count: got %0d, required 3", n_pop);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_high: got %b, required 1", bus.req_ready);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [6];
    int          n_pop = 0;
    int          n_err = 0;
    logic [32:0] e;
    addrs = '{32'h0000_0006, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_0010,
              32'h0000_0003, 32'h0000_0104};
    for (int c = 0; c < 12; c++) begin
      step(c < 6, (c < 6) ? addrs[c] : 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
      if (popd) begin
        n_pop++;
        if (p_err === 1'b1) begin
          n_err++;
          n_checks++;
          if (p_inst !== 32'h0) begin
            n_fail++; $display("FAIL err_inst_zero: got %h, required 00000000", p_inst);
          end
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL err_extra_resp: got %h, required none", p_inst);
        end else begin
          e = exp_q.pop_front();
          if ({p_err, p_inst} !== e) begin
            n_fail++; $display("FAIL err_data: got %h, required %h", {p_err, p_inst}, e);
          end
        end
      end
    end
    n_checks++;
    if (n_pop != 6 || n_err != 5) begin
      n_fail++; $display("FAIL err_counts: got %0d resp/%0d err, required 6/5", n_pop, n_err);
    end
  endtask

  task automatic test_rbw();
    logic [31:0] want [2];
    int          n_pop = 0;
    logic [32:0] e;
    want = '{32'h0000_0033, 32'hDEAD_BEEF};
    step(1'b1, 32'h8, 1'b1, 1'b1, 6'd2, 32'hDEAD_BEEF);
    step(1'b1, 32'h8, 1'b1, 1'b0, 6'd0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
      if (popd) begin
        n_checks++;
        if (n_pop < 2 && p_inst !== want[n_pop]) begin
          n_fail++; $display("FAIL rbw_word[%0d]: got %h, required %h", n_pop, p_inst,
                             want[n_pop]);
        end
        n_pop++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rbw_extra_resp: got %h, required none", p_inst);
        end else begin
          e = exp_q.pop_front();
          if ({p_err, p_inst} !== e) begin
            n_fail++; $display("FAIL rbw_data: got %h, required %h", {p_err, p_inst}, e);
          end
        end
      end
    end
    n_checks++;
    if (n_pop != 2) begin
      n_fail++; $display("FAIL rbw_count: got %0d, required 2", n_pop);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] want [4];
    int          n_pop = 0;
    logic [32:0] e;
    want = '{32'h11, 32'h22, 32'hDEAD_BEEF, 32'h44};
    for (int c = 0; c < 4; c++) step(1'b1, rand_addr(), 1'b0, 1'b0, 6'd0, 32'h0);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_resp_valid: got %b, required 0", bus.resp_valid);
    end
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_req_ready: got %b, required 1", bus.req_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0, 6'd0, 32'h0);
      if (popd) n_pop++;
    end
    n_checks++;
    if (n_pop != 0) begin
      n_fail++; $display("FAIL midrst_stale: got %0d responses, required 0", n_pop);
    end
    for (int c = 0; c < 9; c++) begin
      step(c < 4, 32'(c * 4), 1'b1, 1'b0, 6'd0, 32'h0);
      if (popd) begin
        n_checks++;
        if (n_pop < 4 && p_inst !== want[n_pop]) begin
          n_fail++; $display("FAIL midrst_preserved[%0d]: got %h, required %h", n_pop,
                             p_inst, want[n_pop]);
        end
        n_pop++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end
    end
    n_checks++;
    if (n_pop != 4) begin
      n_fail++; $display("FAIL midrst_count: got %0d, required 4", n_pop);
    end
  endtask

  task automatic test_random();
    int          issued = 0;
    int          n_pop  = 0;
    int          cyc    = 0;
    logic        rr     = 1'b0;
    logic        we;
    logic [32:0] e;
    while ((issued < 200 || exp_q.size() != 0) && cyc < 3000) begin
      we = ($urandom_range(0, 7) == 0);
      step(issued < 200, rand_addr(), rr, we, 6'($urandom_range(0, DEPTH - 1)), $urandom);
      if (acc) issued++;
      if (popd) begin
        n_pop++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_extra_resp: got %h, required none", p_inst);
        end else begin
          e = exp_q.pop_front();
          if ({p_err, p_inst} !== e) begin
            n_fail++; $display("FAIL rand_data[%0d]: got %h, required %h", n_pop,
                               {p_err, p_inst}, e);
          end
        end
      end
      rr = ~rr;
      cyc++;
    end
    n_checks++;
    if (cyc >= 3000) begin
      n_fail++; $display("FAIL rand_timeout: got %0d cycles, required < 3000", cyc);
    end
    n_checks++;
    if (n_pop != 200) begin
      n_fail++; $display("FAIL rand_count: got %0d, required 200", n_pop);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.resp_ready = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = 6'd0;
    wr_data        = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_errors();
    test_rbw();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_fetch_resp.md
Name: imem_fetch_resp

Overview:
- Responder end of the instruction-fetch interface. The PC/fetch side issues word addresses; this block returns instruction words.
- Holds the instruction store: a word array loaded through a write port by the testbench or boot loader.
- Accepts fetch requests with a valid/ready handshake and returns instructions in order through a registered read stage and a 2-entry response buffer.
- Flags misaligned and out-of-range fetches; sits between the pc register and the decode stage.

Parameters:
DEPTH_WORDS, 64, number of 32-bit instruction words stored (power of two, ≥4)
BASE_ADDR, 32'h0000_0000, byte address of word 0
ADDR_W, 32, request address width in bits
DATA_W, 32, instruction width in bits

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  fetch request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  byte address of the instruction
resp_valid  out  1  response at head of buffer
resp_ready  in  1  consumer takes the response this cycle
resp_inst  out  DATA_W  instruction word; 32'h0000_0000 when resp_err=1
resp_err  out  1  1 = misaligned or out-of-range fetch
wr_en  in  1  program-load write strobe
wr_addr  in  log2(DEPTH_WORDS)  word index to write
wr_data  in  DATA_W  instruction word to write

Behaviour:
- Clock and reset: the single clock is clk. The reset is rst, synchronous and active-high.
- Reset effects: s1_valid=0, buffer count=0, resp_valid=0, resp_err=0, resp_inst=0.
  - req_ready=1 from the first cycle after rst deasserts.
  - Array contents are not reset.
  - Reset asserted mid-operation discards all in-flight and buffered responses in that cycle. No response for them is ever produced.
- Request accept: a request is accepted when req_valid && req_ready at a rising edge.
- Ready rule: req_ready = (s1_valid + count) < 3, where count is the buffer occupancy (0..2).
  - This rule is independent of resp_ready, so there is no combinational path from resp_ready to req_ready.
- Stage s1 (registered read), loaded on accept:
  - Misaligned: req_addr[1:0]!=0 gives err=1.
  - Out of range: off=req_addr-BASE_ADDR (ADDR_W-bit unsigned wrap). If off>>2 ≥ DEPTH_WORDS, err=1.
  - Otherwise inst=mem[off>>2], err=0.
  - An erroring request must not index the array.
- Stage s1 to buffer: s1 moves into the buffer when (count<2) || (resp_valid && resp_ready).
  - Otherwise s1 holds its contents. The ready rule guarantees no new accept while s1 is held.
- Buffer: 2-entry FIFO. The head drives resp_valid/resp_inst/resp_err.
  - Pop on resp_valid && resp_ready.
  - Push and pop in the same cycle keeps count unchanged.
  - Ordering is strictly FIFO.
- Latency and throughput:
  - Accept at edge N; resp_valid=1 after edge N+1 when the buffer was empty (2-cycle latency).
  - Sustained throughput is 1 response/cycle with resp_ready held high.
- Back-pressure: at most 3 requests are outstanding (s1 + 2 buffered). With resp_ready=0, req_ready falls after 3 accepts.
- Outputs while resp_valid=0: resp_inst and resp_err hold their last values and are don't-care to the consumer.
- Write port:
  - On wr_en, mem[wr_addr] <= wr_data at the edge.
  - A same-edge read of the same word returns the OLD data (read-before-write).
  - The write port has no handshake and is always accepted, including during rst.

Decomposition:
- Shared package imem_pkg:
  - IMEM_ERR_NONE / IMEM_ERR_FAULT constants.
  - NOP_ON_FAULT = 32'h0000_0000.
  - Function word_index(addr, base) returning {oob, misaligned, index}.
- One sub-module, imem_resp_fifo: 2-entry FIFO of {err, inst} with push, pop, count, head outputs and synchronous active-high rst.
- The array, s1 stage and ready logic stay in the top module.

Test Plan:
- Load mem[0..3]=11,22,33,44 (hex words); after rst, stream addrs 0,4,8,C with resp_ready=1 -> responses 11,22,33,44 on 4 consecutive cycles, first one 2 cycles after the first accept, resp_err=0, req_ready stays 1.
- Stream with resp_ready=0 -> exactly 3 accepts, then req_ready=0. Raise resp_ready -> 3 responses in order, then req_ready=1 again.
- Request addr 32'h0000_0006 -> resp_err=1, resp_inst=0. Request addr BASE_ADDR+4*DEPTH_WORDS (32'h100) -> resp_err=1. Request addr 32'hFFFF_FFFC with BASE_ADDR=0 -> resp_err=1 (wrap, out of range).
- Same edge: wr_en to word 2 with 32'hDEAD_BEEF and accepted fetch of addr 8 -> returns old word 33. A following fetch of addr 8 -> DEAD_BEEF.
- Fill buffer with 2 responses and s1 valid, assert rst for 1 cycle -> resp_valid=0 and req_ready=1 next cycle, no stale responses ever appear, array contents preserved.
- Alternate resp_ready 1/0 every cycle under continuous requests -> no lost or duplicated responses, order preserved; check with a scoreboard over 200 random aligned in-range addresses.
